// File: rtl/mul_cdb_buffer_pkg.sv
// mul_cdb_buffer_pkg
// Shared definitions for the multiply completion buffer: the machine
// widths (XLEN, PRF_LEN, ROB_LEN) and the MUL_CDB_ENTRY record that is
// stored per FIFO slot and presented on the CDB. This is the slice of
// sys_defs that the buffer depends on, kept next to RS_MUL_PACKET there.
// No ports (package).
package mul_cdb_buffer_pkg;

    localparam int XLEN    = 32;
    localparam int PRF_LEN = 6;
    localparam int ROB_LEN = 5;

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    PC;
    } MUL_CDB_ENTRY;

    localparam int ENTRY_W = $bits(MUL_CDB_ENTRY);

endpackage

// File: rtl/mul_cdb_buffer_if.sv
// mul_cdb_buffer_if
// Bundles the multiplier result port, RS credit, squash and the CDB
// request/grant handshake of the completion buffer.
// Modports:
//   slave  - the buffer: takes mul_*, squash, cdb_grant; drives cdb_*,
//            mul_issue_ok and buf_count.
//   master - the surrounding pipeline (RS, multiplier, CDB arbiter).
interface mul_cdb_buffer_if
    import mul_cdb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                         mul_issue;
    logic                         mul_valid;
    logic [XLEN-1:0]              mul_value;
    logic [PRF_LEN-1:0]           mul_prf_idx;
    logic [ROB_LEN-1:0]           mul_rob_idx;
    logic [XLEN-1:0]              mul_PC;
    logic                         squash;
    logic                         cdb_grant;
    logic                         cdb_req;
    logic [XLEN-1:0]              cdb_value;
    logic [PRF_LEN-1:0]           cdb_prf_idx;
    logic [ROB_LEN-1:0]           cdb_rob_idx;
    logic [XLEN-1:0]              cdb_PC;
    logic                         mul_issue_ok;
    logic [$clog2(DEPTH+1)-1:0]   buf_count;

    modport slave (
        input  mul_issue, mul_valid, mul_value, mul_prf_idx, mul_rob_idx,
               mul_PC, squash, cdb_grant,
        output cdb_req, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC,
               mul_issue_ok, buf_count
    );

    modport master (
        output mul_issue, mul_valid, mul_value, mul_prf_idx, mul_rob_idx,
               mul_PC, squash, cdb_grant,
        input  cdb_req, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC,
               mul_issue_ok, buf_count
    );

endinterface

// File: rtl/mul_cdb_buffer_fifo.sv
// mul_cdb_buffer_fifo
// Generic in-order storage array with head/tail pointers and occupancy.
// Read is asynchronous from the head slot so the head entry is visible
// the cycle after it is written. The caller must not push while full
// without popping, nor pop while empty.
// Ports:
//   clock, reset (synchronous, active-low: clears pointers and all slots)
//   clear  - drop all entries (pointers/count to 0, slot data kept)
//   push, wdata - write at tail;  pop - advance head
//   rdata  - head slot contents;  count - occupied slots
module mul_cdb_buffer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic [DEPTH-1:0] write_en;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign write_en[gi] = push && !clear && (tail_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (write_en[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem_reg[head_reg];
    assign count = count_reg;

endmodule

// File: rtl/mul_cdb_buffer.sv
// mul_cdb_buffer
// Completion buffer between the stall-free pipelined multiplier and the
// CDB arbiter. Every result is captured in an in-order FIFO and offered
// to the CDB with request/grant. A credit (mul_issue_ok) keeps buffered
// plus in-flight results within DEPTH, and results already inside the
// multiplier when a squash hits are counted off and discarded.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-low
//   bus    - mul_cdb_buffer_if.slave (multiplier result, issue strobe,
//            squash, CDB request/grant, credit and occupancy)
module mul_cdb_buffer
    import mul_cdb_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 8
) (
    input  logic            clock,
    input  logic            reset,
    mul_cdb_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int LAT_W = $clog2(MUL_LAT+1);

    logic [LAT_W-1:0] inflight_reg;
    logic [LAT_W-1:0] inflight_next;
    logic [LAT_W-1:0] drop_cnt_reg;
    logic [LAT_W-1:0] drop_cnt_next;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             cdb_req;
    MUL_CDB_ENTRY     wr_entry;
    MUL_CDB_ENTRY     head_entry;

    // Tracks the multiplier pipe occupancy regardless of squash, so the
    // drop count always matches what will still come out of the pipe.
    assign inflight_next = inflight_reg + LAT_W'(bus.mul_issue) - LAT_W'(bus.mul_valid);

    assign cdb_req = (fifo_count != '0);
    assign push    = bus.mul_valid && !bus.squash && (drop_cnt_reg == '0);
    assign pop     = bus.cdb_grant && cdb_req && !bus.squash;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (bus.squash) begin
            // Includes a multiply issued in the squash cycle and excludes
            // the result retiring from the pipe in the same cycle.
            drop_cnt_next = inflight_next;
        end else if (bus.mul_valid && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - LAT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign wr_entry = '{value:   bus.mul_value,
                        prf_idx: bus.mul_prf_idx,
                        rob_idx: bus.mul_rob_idx,
                        PC:      bus.mul_PC};

    mul_cdb_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (bus.squash),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head_entry),
        .count (fifo_count)
    );

    // Credit is registered-state only; a grant this cycle shows up as
    // extra credit next cycle, which keeps this off the arbiter path.
    assign bus.mul_issue_ok = (int'(fifo_count) + int'(inflight_reg)) < DEPTH;

    assign bus.cdb_req     = cdb_req;
    assign bus.cdb_value   = head_entry.value;
    assign bus.cdb_prf_idx = head_entry.prf_idx;
    assign bus.cdb_rob_idx = head_entry.rob_idx;
    assign bus.cdb_PC      = head_entry.PC;
    assign bus.buf_count   = fifo_count;

endmodule

// File: tb/tb_mul_cdb_buffer.sv
// tb_mul_cdb_buffer
// Directed bench for mul_cdb_buffer (DEPTH 4, MUL_LAT 8). Inputs change
// on the falling edge; outputs are examined on the falling edge, half a
// cycle after the rising edge that updated them.
module tb_mul_cdb_buffer;
    import mul_cdb_buffer_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total_checks = 0;
    int   passed_checks = 0;

    always #5 clock = ~clock;

    mul_cdb_buffer_if #(.DEPTH(DEPTH)) bus ();

    mul_cdb_buffer #(
        .DEPTH   (DEPTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clock) begin
        if (reset) begin
            assert (!(dut.push && !dut.pop && int'(bus.buf_count) == DEPTH))
                else $error("overflow: push into full buffer without pop");
            assert (!(bus.mul_valid && !bus.mul_issue && dut.inflight_reg == '0))
                else $error("inflight underflow");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", passed_checks, total_checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.mul_issue   = 1'b0;
        bus.mul_valid   = 1'b0;
        bus.mul_value   = '0;
        bus.mul_prf_idx = '0;
        bus.mul_rob_idx = '0;
        bus.mul_PC      = '0;
        bus.squash      = 1'b0;
        bus.cdb_grant   = 1'b0;
    endtask

    task automatic result(input int rob, input logic [XLEN-1:0] val);
        bus.mul_valid   = 1'b1;
        bus.mul_rob_idx = ROB_LEN'(rob);
        bus.mul_value   = val;
        bus.mul_prf_idx = PRF_LEN'(rob + 1);
        bus.mul_PC      = XLEN'(32'h1000 + rob * 4);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        total_checks++;
        if (bus.cdb_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", bus.cdb_req);
        else passed_checks++;
        total_checks++;
        if (bus.buf_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.buf_count);
        else passed_checks++;
        total_checks++;
        if (bus.mul_issue_ok !== 1'b1) $display("FAIL reset_ok: got %0b want 1", bus.mul_issue_ok);
        else passed_checks++;
        total_checks++;
        if (bus.cdb_value !== 32'd0 || bus.cdb_PC !== 32'd0)
            $display("FAIL reset_data: got value %h PC %h want 0", bus.cdb_value, bus.cdb_PC);
        else passed_checks++;
        total_checks++;
        if (bus.cdb_rob_idx !== 5'd0 || bus.cdb_prf_idx !== 6'd0)
            $display("FAIL reset_idx: got rob %0d prf %0d want 0", bus.cdb_rob_idx, bus.cdb_prf_idx);
        else passed_checks++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.mul_issue = 1'b1;
        tick();
        bus.mul_issue = 1'b0;
        bus.mul_valid   = 1'b1;
        bus.mul_value   = 32'h0000_0C35;
        bus.mul_prf_idx = 6'd5;
        bus.mul_rob_idx = 5'd3;
        bus.mul_PC      = 32'h0000_0100;
        total_checks++;
        if (bus.cdb_req !== 1'b0) $display("FAIL single_no_bypass: got req %0b want 0", bus.cdb_req);
        else passed_checks++;
        tick();
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.cdb_req !== 1'b1) $display("FAIL single_req: got %0b want 1", bus.cdb_req);
        else passed_checks++;
        total_checks++;
        if (bus.cdb_value !== 32'h0000_0C35 || bus.cdb_PC !== 32'h0000_0100)
            $display("FAIL single_data: got value %h PC %h want 00000c35 00000100", bus.cdb_value, bus.cdb_PC);
        else passed_checks++;
        total_checks++;
        if (bus.cdb_prf_idx !== 6'd5 || bus.cdb_rob_idx !== 5'd3)
            $display("FAIL single_idx: got prf %0d rob %0d want 5 3", bus.cdb_prf_idx, bus.cdb_rob_idx);
        else passed_checks++;
        total_checks++;
        if (bus.buf_count !== 3'd1) $display("FAIL single_count: got %0d want 1", bus.buf_count);
        else passed_checks++;
        $display("single: pop rob=%0d value=%h", bus.cdb_rob_idx, bus.cdb_value);
        bus.cdb_grant = 1'b1;
        tick();
        bus.cdb_grant = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd0 || bus.cdb_req !== 1'b0)
            $display("FAIL single_pop: got count %0d req %0b want 0 0", bus.buf_count, bus.cdb_req);
        else passed_checks++;
    endtask

    // Leaves 3 results buffered (rob 10..12) and 1 multiply in flight.
    task automatic test_back_pressure();
        int issued = 0;
        for (int i = 0; i < 8; i++) begin
            bus.mul_issue = bus.mul_issue_ok;
            if (bus.mul_issue_ok) issued++;
            tick();
        end
        bus.mul_issue = 1'b0;
        total_checks++;
        if (issued != 4) $display("FAIL bp_issued: got %0d want 4", issued);
        else passed_checks++;
        total_checks++;
        if (bus.mul_issue_ok !== 1'b0) $display("FAIL bp_ok: got %0b want 0", bus.mul_issue_ok);
        else passed_checks++;
        total_checks++;
        if (int'(dut.inflight_reg) + int'(bus.buf_count) != 4)
            $display("FAIL bp_credit_sum: got %0d want 4", int'(dut.inflight_reg) + int'(bus.buf_count));
        else passed_checks++;
        for (int r = 10; r < 13; r++) begin
            result(r, XLEN'(r * 100));
            tick();
            $display("bp: push rob=%0d", r);
        end
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd3 || bus.mul_issue_ok !== 1'b0)
            $display("FAIL bp_three: got count %0d ok %0b want 3 0", bus.buf_count, bus.mul_issue_ok);
        else passed_checks++;
    endtask

    task automatic test_full_push_pop();
        // RS deliberately issues one beyond the credit to reach full with a result pending.
        bus.mul_issue = 1'b1;
        result(13, 32'd1300);
        tick();
        bus.mul_issue = 1'b0;
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd4 || bus.cdb_rob_idx !== 5'd10)
            $display("FAIL full_state: got count %0d head %0d want 4 10", bus.buf_count, bus.cdb_rob_idx);
        else passed_checks++;
        result(14, 32'd1400);
        bus.cdb_grant = 1'b1;
        tick();
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd4 || bus.cdb_rob_idx !== 5'd11)
            $display("FAIL full_pushpop: got count %0d head %0d want 4 11", bus.buf_count, bus.cdb_rob_idx);
        else passed_checks++;
        for (int k = 0; k < 4; k++) begin
            total_checks++;
            if (bus.cdb_rob_idx !== ROB_LEN'(11 + k) || bus.cdb_req !== 1'b1)
                $display("FAIL full_drain: got rob %0d req %0b want %0d 1", bus.cdb_rob_idx, bus.cdb_req, 11 + k);
            else passed_checks++;
            $display("full: pop rob=%0d value=%0d", bus.cdb_rob_idx, bus.cdb_value);
            tick();
        end
        bus.cdb_grant = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd0 || bus.mul_issue_ok !== 1'b1)
            $display("FAIL full_empty: got count %0d ok %0b want 0 1", bus.buf_count, bus.mul_issue_ok);
        else passed_checks++;
    endtask

    task automatic test_wrap_order();
        int got = 0;
        int issued = 0;
        int delivered = 0;
        logic pipe = 1'b0;
        logic pipe_next;
        for (int c = 0; c < 100 && got < 10; c++) begin
            if (pipe) result(delivered, XLEN'(delivered * 7));
            else bus.mul_valid = 1'b0;
            bus.mul_issue = bus.mul_issue_ok && (issued < 10);
            bus.cdb_grant = (c % 2) == 1;
            if (bus.cdb_grant && bus.cdb_req) begin
                total_checks++;
                if (bus.cdb_rob_idx !== ROB_LEN'(got))
                    $display("FAIL wrap_order: got rob %0d want %0d", bus.cdb_rob_idx, got);
                else passed_checks++;
                $display("wrap: pop rob=%0d value=%0d", bus.cdb_rob_idx, bus.cdb_value);
                got++;
            end
            pipe_next = bus.mul_issue;
            if (bus.mul_valid) delivered++;
            if (bus.mul_issue) issued++;
            tick();
            pipe = pipe_next;
        end
        idle_inputs();
        total_checks++;
        if (got != 10 || bus.buf_count !== 3'd0)
            $display("FAIL wrap_done: got %0d popped count %0d want 10 0", got, bus.buf_count);
        else passed_checks++;
    endtask

    task automatic test_squash();
        // Five issues ignoring credit so that 2 are buffered and 3 still in the pipe.
        bus.mul_issue = 1'b1;
        repeat (5) tick();
        bus.mul_issue = 1'b0;
        result(20, 32'd2000);
        tick();
        result(21, 32'd2100);
        tick();
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd2) $display("FAIL sq_pre: got count %0d want 2", bus.buf_count);
        else passed_checks++;
        bus.squash = 1'b1;
        tick();
        bus.squash = 1'b0;
        $display("squash: issued flush");
        total_checks++;
        if (bus.cdb_req !== 1'b0 || bus.buf_count !== 3'd0)
            $display("FAIL sq_req: got req %0b count %0d want 0 0", bus.cdb_req, bus.buf_count);
        else passed_checks++;
        total_checks++;
        if (dut.drop_cnt_reg !== 4'd3) $display("FAIL sq_drop: got %0d want 3", dut.drop_cnt_reg);
        else passed_checks++;
        bus.mul_issue = 1'b1;
        tick();
        bus.mul_issue = 1'b0;
        for (int k = 0; k < 3; k++) begin
            result(25 + k, 32'hDEAD);
            tick();
        end
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd0 || bus.cdb_req !== 1'b0)
            $display("FAIL sq_dropped: got count %0d req %0b want 0 0", bus.buf_count, bus.cdb_req);
        else passed_checks++;
        total_checks++;
        if (dut.drop_cnt_reg !== 4'd0) $display("FAIL sq_drop_zero: got %0d want 0", dut.drop_cnt_reg);
        else passed_checks++;
        result(24, 32'h2424);
        tick();
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.cdb_req !== 1'b1 || bus.cdb_rob_idx !== 5'd24 || bus.cdb_value !== 32'h2424)
            $display("FAIL sq_after: got req %0b rob %0d value %h want 1 24 00002424",
                     bus.cdb_req, bus.cdb_rob_idx, bus.cdb_value);
        else passed_checks++;
        bus.cdb_grant = 1'b1;
        tick();
        bus.cdb_grant = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd0 || bus.mul_issue_ok !== 1'b1)
            $display("FAIL sq_idle: got count %0d ok %0b want 0 1", bus.buf_count, bus.mul_issue_ok);
        else passed_checks++;
    endtask

    task automatic test_squash_same_cycle();
        bus.mul_issue = 1'b1;
        repeat (2) tick();
        bus.mul_issue = 1'b0;
        result(30, 32'd3000);
        tick();
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd1) $display("FAIL ssc_pre: got count %0d want 1", bus.buf_count);
        else passed_checks++;
        // inflight is 1 here; squash with issue, valid and grant all at once.
        bus.squash    = 1'b1;
        bus.mul_issue = 1'b1;
        bus.cdb_grant = 1'b1;
        result(31, 32'd3100);
        tick();
        idle_inputs();
        $display("squash_same: flush with issue+valid+grant");
        total_checks++;
        if (bus.buf_count !== 3'd0 || bus.cdb_req !== 1'b0)
            $display("FAIL ssc_empty: got count %0d req %0b want 0 0", bus.buf_count, bus.cdb_req);
        else passed_checks++;
        total_checks++;
        if (dut.drop_cnt_reg !== 4'd1) $display("FAIL ssc_drop: got %0d want 1", dut.drop_cnt_reg);
        else passed_checks++;
        total_checks++;
        if (dut.inflight_reg !== 4'd1) $display("FAIL ssc_inflight: got %0d want 1", dut.inflight_reg);
        else passed_checks++;
        result(32, 32'd3200);
        tick();
        bus.mul_valid = 1'b0;
        total_checks++;
        if (bus.buf_count !== 3'd0 || dut.drop_cnt_reg !== 4'd0 || bus.mul_issue_ok !== 1'b1)
            $display("FAIL ssc_drain: got count %0d drop %0d ok %0b want 0 0 1",
                     bus.buf_count, dut.drop_cnt_reg, bus.mul_issue_ok);
        else passed_checks++;
    endtask

    task automatic test_reset_mid();
        bus.mul_issue = 1'b1;
        tick();
        bus.mul_issue = 1'b0;
        result(7, 32'h0777);
        tick();
        bus.mul_valid = 1'b0;
        reset = 1'b0;
        tick();
        $display("reset_mid: reset with 1 buffered");
        total_checks++;
        if (bus.buf_count !== 3'd0 || bus.cdb_req !== 1'b0)
            $display("FAIL rmid_empty: got count %0d req %0b want 0 0", bus.buf_count, bus.cdb_req);
        else passed_checks++;
        total_checks++;
        if (bus.cdb_value !== 32'd0 || bus.cdb_rob_idx !== 5'd0)
            $display("FAIL rmid_data: got value %h rob %0d want 0 0", bus.cdb_value, bus.cdb_rob_idx);
        else passed_checks++;
        reset = 1'b1;
        tick();
        total_checks++;
        if (bus.mul_issue_ok !== 1'b1 || dut.inflight_reg !== 4'd0)
            $display("FAIL rmid_credit: got ok %0b inflight %0d want 1 0", bus.mul_issue_ok, dut.inflight_reg);
        else passed_checks++;
    endtask

    initial begin
        idle_inputs();
        tick();
        test_reset();
        test_single();
        test_back_pressure();
        test_full_push_pop();
        test_wrap_order();
        test_squash();
        test_squash_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
